// File: rtl/sram_adapter_pkg.sv
// Shared constants for the SRAM request adapter and its response buffer.
package sram_adapter_pkg;

    // Below two entries the credit loop cannot sustain one request per cycle.
    localparam int SRAM_ADAPTER_MIN_DEPTH = 2;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Small response buffer: push/pop with occupancy count, pointers wrap modulo DEPTH.
module sram_rsp_fifo
    import sram_adapter_pkg::*;
#(
    parameter int WIDTH = 65,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] cnt,
    output logic                       empty
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign cnt   = count;
    assign empty = (count == '0);

endmodule

// File: rtl/sram_req_adapter.sv
// Valid/ready front-end for one RAM port: issues strobes, captures registered
// read data one cycle later and returns in-order responses via a bypassable buffer.
module sram_req_adapter
    import sram_adapter_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_we_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_be_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_write_o,
    output logic                    ram_en_o,
    output logic                    ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  write;
    } rsp_t;

    if (RSP_DEPTH < SRAM_ADAPTER_MIN_DEPTH) begin : g_bad_depth
        $error("sram_req_adapter: RSP_DEPTH must be at least %0d", SRAM_ADAPTER_MIN_DEPTH);
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("sram_req_adapter: DATA_WIDTH must be a multiple of 8");
    end

    logic          fire;
    logic          inflight;
    logic          inflight_we;
    logic          rsp_hs;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_empty;
    logic [CW-1:0] fifo_cnt;
    rsp_t          live_rsp;
    rsp_t          fifo_head;
    rsp_t          rsp_sel;

    assign fire        = req_valid_i && req_ready_o;
    assign ram_en_o    = fire;
    assign ram_we_o    = fire && req_we_i;
    assign ram_addr_o  = req_addr_i;
    assign ram_wdata_o = req_wdata_i;
    assign ram_be_o    = req_be_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight    <= 1'b0;
            inflight_we <= 1'b0;
        end else begin
            inflight    <= fire;
            inflight_we <= req_we_i;
        end
    end

    // Write responses carry zero data regardless of what the RAM drives.
    assign live_rsp.rdata = inflight_we ? '0 : ram_rdata_i;
    assign live_rsp.write = inflight_we;

    assign rsp_sel     = fifo_empty ? live_rsp : fifo_head;
    assign rsp_valid_o = !rst && (!fifo_empty || inflight);
    assign rsp_rdata_o = rsp_sel.rdata;
    assign rsp_write_o = rsp_sel.write;
    assign rsp_hs      = rsp_valid_o && rsp_ready_i;

    // The live result is stored unless it was handed straight to the requester.
    assign fifo_push = inflight && !(fifo_empty && rsp_ready_i);
    assign fifo_pop  = rsp_hs && !fifo_empty;

    // Credit counts the in-flight result; a pop this cycle frees a slot early.
    assign req_ready_o = !rst &&
                         (((int'(fifo_cnt) + int'(inflight)) < RSP_DEPTH) || rsp_hs);

    sram_rsp_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (live_rsp),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .cnt       (fifo_cnt),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_sram_req_adapter.sv
// Directed and randomized checks of sram_req_adapter against a RAM model and a queue-based reference.
module tb_sram_req_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_addr;
    logic        req_we;
    logic [63:0] req_wdata;
    logic [7:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_write;
    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [63:0] ram_wdata;
    logic [7:0]  ram_be;
    logic [63:0] ram_q;

    always #5 clk = ~clk;

    sram_req_adapter #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (64),
        .RSP_DEPTH  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_we_i    (req_we),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_write_o (rsp_write),
        .ram_en_o    (ram_en),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_wdata_o (ram_wdata),
        .ram_be_o    (ram_be),
        .ram_rdata_i (ram_q)
    );

    // RAM port with registered read data.
    logic [63:0] ram [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 8; b++)
                    if (ram_be[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_q <= ram[ram_addr];
            end
        end
    end

    typedef struct {
        logic [63:0] rdata;
        logic        write;
    } exp_t;

    logic [63:0] ref_mem [256];
    exp_t        exp_q [$];
    int          total = 0;
    int          bad   = 0;
    bit          prev_hold = 1'b0;
    logic [63:0] prev_data;
    logic        prev_write;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called between negedge and posedge: inputs and DUT outputs are settled.
    task automatic scoreboard();
        exp_t e;
        bit   fire;
        if (rst) begin
            exp_q.delete();
            prev_hold = 1'b0;
            return;
        end
        fire = req_valid && req_ready;
        chk("ram_en", 64'(ram_en), 64'(fire));
        chk("ram_we", 64'(ram_we), 64'(fire && req_we));
        if (fire) chk("ram_addr", 64'(ram_addr), 64'(req_addr));
        if (prev_hold) begin
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_rdata", rsp_rdata, prev_data);
            chk("hold_write", 64'(rsp_write), 64'(prev_write));
        end
        if (rsp_valid) chk("rsp_spurious", 64'(exp_q.size() != 0), 64'd1);
        if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_write", 64'(rsp_write), 64'(e.write));
        end
        if (fire) begin
            if (req_we) begin
                for (int b = 0; b < 8; b++)
                    if (req_be[b]) ref_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                e.rdata = 64'd0;
                e.write = 1'b1;
            end else begin
                e.rdata = ref_mem[req_addr];
                e.write = 1'b0;
            end
            exp_q.push_back(e);
        end
        prev_hold  = rsp_valid && !rsp_ready;
        prev_data  = rsp_rdata;
        prev_write = rsp_write;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic fin();
        scoreboard();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        half();
        fin();
    endtask

    task automatic set_req(input logic we, input logic [7:0] a, input logic [63:0] d, input logic [7:0] be);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
    endtask

    task automatic idle();
        req_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b1;

        repeat (2) begin
            half();
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_ram_en", 64'(ram_en), 64'd0);
            fin();
        end
        rst = 1'b0;
        half();
        chk("idle_req_ready", 64'(req_ready), 64'd1);
        chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("idle_ram_en", 64'(ram_en), 64'd0);
        fin();

        // Preload the working address range with random data.
        for (int i = 0; i < 32; i++) begin
            set_req(1'b1, 8'(i), {$urandom, $urandom}, 8'hFF);
            cycle();
        end
        idle();
        repeat (2) cycle();

        // Write then read back-to-back.
        set_req(1'b1, 8'h10, 64'hDEADBEEF_01234567, 8'hFF);
        half();
        chk("wr_accept", 64'(req_ready), 64'd1);
        fin();
        set_req(1'b0, 8'h10, 64'd0, 8'h00);
        half();
        chk("wr_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("wr_rsp_write", 64'(rsp_write), 64'd1);
        chk("wr_rsp_rdata", rsp_rdata, 64'd0);
        fin();
        idle();
        half();
        chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rd_rsp_write", 64'(rsp_write), 64'd0);
        chk("rd_rsp_rdata", rsp_rdata, 64'hDEADBEEF_01234567);
        fin();

        // Partial write over a zeroed word.
        set_req(1'b1, 8'h20, 64'd0, 8'hFF);
        cycle();
        set_req(1'b1, 8'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        cycle();
        set_req(1'b0, 8'h20, 64'd0, 8'h00);
        cycle();
        idle();
        half();
        chk("partial_valid", 64'(rsp_valid), 64'd1);
        chk("partial_rdata", rsp_rdata, 64'h0000_0000_FFFF_FFFF);
        fin();

        // Streaming reads, one per cycle.
        for (int i = 0; i < 16; i++) begin
            set_req(1'b0, 8'(i), 64'd0, 8'h00);
            half();
            chk("stream_ready", 64'(req_ready), 64'd1);
            if (i > 0) begin
                chk("stream_valid", 64'(rsp_valid), 64'd1);
                chk("stream_rdata", rsp_rdata, ref_mem[i-1]);
            end
            fin();
        end
        idle();
        half();
        chk("stream_last_valid", 64'(rsp_valid), 64'd1);
        chk("stream_last_rdata", rsp_rdata, ref_mem[15]);
        fin();
        half();
        chk("stream_done", 64'(rsp_valid), 64'd0);
        fin();

        // Backpressure: two credits, then stall.
        rsp_ready = 1'b0;
        set_req(1'b0, 8'd1, 64'd0, 8'h00);
        half();
        chk("bp_acc1", 64'(req_ready), 64'd1);
        fin();
        set_req(1'b0, 8'd2, 64'd0, 8'h00);
        half();
        chk("bp_acc2", 64'(req_ready), 64'd1);
        fin();
        set_req(1'b0, 8'd3, 64'd0, 8'h00);
        repeat (3) begin
            half();
            chk("bp_stall_ready", 64'(req_ready), 64'd0);
            chk("bp_stall_valid", 64'(rsp_valid), 64'd1);
            chk("bp_stall_rdata", rsp_rdata, ref_mem[1]);
            fin();
        end
        rsp_ready = 1'b1;
        half();
        chk("bp_drain1", rsp_rdata, ref_mem[1]);
        chk("bp_acc3", 64'(req_ready), 64'd1);
        fin();
        idle();
        half();
        chk("bp_drain2", rsp_rdata, ref_mem[2]);
        fin();
        half();
        chk("bp_drain3_valid", 64'(rsp_valid), 64'd1);
        chk("bp_drain3", rsp_rdata, ref_mem[3]);
        fin();
        half();
        chk("bp_empty", 64'(rsp_valid), 64'd0);
        fin();

        // Reset with two buffered responses.
        rsp_ready = 1'b0;
        set_req(1'b0, 8'd5, 64'd0, 8'h00);
        cycle();
        set_req(1'b0, 8'd6, 64'd0, 8'h00);
        cycle();
        idle();
        half();
        chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
        fin();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        half();
        chk("post_rst_valid", 64'(rsp_valid), 64'd0);
        chk("post_rst_ready", 64'(req_ready), 64'd1);
        fin();
        rsp_ready = 1'b1;
        set_req(1'b0, 8'd7, 64'd0, 8'h00);
        cycle();
        idle();
        half();
        chk("fresh_valid", 64'(rsp_valid), 64'd1);
        chk("fresh_rdata", rsp_rdata, ref_mem[7]);
        fin();

        // Random traffic with random backpressure.
        for (int n = 0; n < 400; n++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = 8'($urandom_range(0, 31));
            req_wdata = {$urandom, $urandom};
            req_be    = 8'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        idle();
        rsp_ready = 1'b1;
        guard = 0;
        while ((exp_q.size() != 0 || rsp_valid) && guard < 20) begin
            cycle();
            guard++;
        end
        chk("drain_timeout", 64'(guard < 20), 64'd1);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
